accelerator: RTL and testbench

//  Single-issue, single-cycle programmable integer compute core: executes a program

---
 rtl/accelerator_if.sv | 13 +
 rtl/accelerator.sv | 137 +++++++++++++
 tb/tb_accelerator.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accelerator_if.sv
// Status bundle of the accelerator core.
//   halted : 1 once HALT has executed (core -> observer)
//   pc     : current program counter (core -> observer)
// master = the core that drives the status, slave = whoever observes it.
interface accelerator_if #(
  parameter int unsigned PC_W = 8
);
  logic            halted;
  logic [PC_W-1:0] pc;

  modport master (output halted, output pc);
  modport slave  (input  halted, input  pc);
endinterface

// File: rtl/accelerator.sv
// Single-issue, single-cycle integer compute core. Executes a program from the
// internal instruction ROM `instructions` over the signed scratchpad `memory`
// and an eight-entry register file. Both arrays are preloaded hierarchically.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-low reset (pc, halted, registers cleared;
//            instruction and data arrays keep their contents)
//   status : accelerator_if.master -- halted flag and program counter
// Configuration macro: ACCEL_MAC_EN enables opcode C as multiply-accumulate
// (rd = rd + rs*rt); without it opcode C decodes as NOP.
module accelerator #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  accelerator_if.master status
);

  localparam int unsigned PC_W   = $clog2(IMEM_DEPTH);
  localparam int unsigned DA_W   = $clog2(DMEM_DEPTH);
  localparam int unsigned NREG   = 8;
  localparam int unsigned RIDX_W = 3;
  localparam int unsigned INSN_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_MUL  = 4'h6,
    OP_ADDI = 4'h7,
    OP_MAX  = 4'h8,
    OP_RELU = 4'h9,
    OP_BNEZ = 4'hA,
    OP_JMP  = 4'hB,
    OP_MAC  = 4'hC,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  // Architectural storage; array names are fixed because they are preloaded by name.
  logic [INSN_W-1:0]        instructions [IMEM_DEPTH];
  logic signed [DATA_W-1:0] memory       [DMEM_DEPTH];
  logic signed [DATA_W-1:0] regs_q       [NREG];

  logic [PC_W-1:0] pc_q, pc_d;
  state_e          state_q, state_d;

  // Decode of the current instruction word
  logic [INSN_W-1:0]        insn;
  op_e                      op;
  logic [RIDX_W-1:0]        rd, rs, rt;
  logic [5:0]               imm6;
  logic [8:0]               imm9;
  logic signed [DATA_W-1:0] rd_v, rs_v, rt_v;
  logic signed [DATA_W-1:0] sext6, sext9, prod;
  logic [DA_W-1:0]          ea;

  logic                     reg_we;
  logic signed [DATA_W-1:0] reg_wd;
  logic                     mem_we;

  assign insn  = instructions[pc_q];
  assign op    = op_e'(insn[15:12]);
  assign rd    = insn[11:9];
  assign rs    = insn[8:6];
  assign rt    = insn[2:0];
  assign imm6  = insn[5:0];
  assign imm9  = insn[8:0];

  assign rd_v  = regs_q[rd];
  assign rs_v  = regs_q[rs];
  assign rt_v  = regs_q[rt];
  assign sext6 = DATA_W'($signed(imm6));
  assign sext9 = DATA_W'($signed(imm9));
  assign prod  = rs_v * rt_v;

  // Scratchpad depth is a power of two, so truncation is the modulo (negatives wrap).
  assign ea    = DA_W'(rs_v + sext6);

  // Next-state / execute: unknown, reserved and disabled opcodes fall to the NOP default.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    reg_we  = 1'b0;
    reg_wd  = '0;
    mem_we  = 1'b0;
    if (state_q == S_RUN) begin
      pc_d = pc_q + PC_W'(1);
      case (op)
        OP_LDI:  begin reg_we = 1'b1; reg_wd = sext9;           end
        OP_LD:   begin reg_we = 1'b1; reg_wd = memory[ea];      end
        OP_ST:   mem_we = 1'b1;
        OP_ADD:  begin reg_we = 1'b1; reg_wd = rs_v + rt_v;     end
        OP_SUB:  begin reg_we = 1'b1; reg_wd = rs_v - rt_v;     end
        OP_MUL:  begin reg_we = 1'b1; reg_wd = prod;            end
        OP_ADDI: begin reg_we = 1'b1; reg_wd = rs_v + sext6;    end
        OP_MAX:  begin reg_we = 1'b1; reg_wd = (rs_v > rt_v) ? rs_v : rt_v; end
        OP_RELU: begin reg_we = 1'b1; reg_wd = rs_v[DATA_W-1] ? '0 : rs_v;  end
        // Offset is taken modulo the ROM depth, so only its low PC_W bits matter.
        OP_BNEZ: if (rd_v != '0) pc_d = pc_q + PC_W'(imm9);
        OP_JMP:  pc_d = PC_W'(imm9);
`ifdef ACCEL_MAC_EN
        OP_MAC:  begin reg_we = 1'b1; reg_wd = rd_v + prod;     end
`endif
        OP_HALT: begin state_d = S_HALT; pc_d = pc_q;           end
        default: ;
      endcase
    end
  end

  // State, register file and scratchpad update; the scratchpad is never cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (reg_we) regs_q[rd] <= reg_wd;
      if (mem_we) memory[ea] <= rd_v;
    end
  end

  assign status.pc     = pc_q;
  assign status.halted = (state_q == S_HALT);

endmodule

// File: tb/tb_accelerator.sv
// Self-checking bench for the accelerator core: directed programs plus random
// straight-line programs, checked against an instruction-level reference model.
module tb_accelerator;

`ifdef ACCEL_MAC_EN
  localparam bit MAC_EN = 1'b1;
`else
  localparam bit MAC_EN = 1'b0;
`endif

  localparam int OP_NOP  = 0;
  localparam int OP_LDI  = 1;
  localparam int OP_LD   = 2;
  localparam int OP_ST   = 3;
  localparam int OP_ADD  = 4;
  localparam int OP_SUB  = 5;
  localparam int OP_MUL  = 6;
  localparam int OP_ADDI = 7;
  localparam int OP_MAX  = 8;
  localparam int OP_RELU = 9;
  localparam int OP_BNEZ = 10;
  localparam int OP_JMP  = 11;
  localparam int OP_MAC  = 12;
  localparam logic [15:0] HALT_W = 16'hF000;

  logic clk;
  logic rst;

  accelerator_if #(.PC_W(8)) st ();

  accelerator dut (
    .clk    (clk),
    .rst    (rst),
    .status (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0]        m_imem [256];
  logic signed [31:0] m_mem  [32];
  logic signed [31:0] m_reg  [8];
  logic [7:0]         m_pc;
  bit                 m_halt;

  int n_cmp;
  int n_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] i_r(input int op, input int rd, input int rs, input int imm6);
    return {4'(op), 3'(rd), 3'(rs), 6'(imm6)};
  endfunction

  function automatic logic [15:0] i_9(input int op, input int rd, input int imm9);
    return {4'(op), 3'(rd), 9'(imm9)};
  endfunction

  // One architectural instruction, straight from the ISA description.
  task automatic model_step();
    logic [15:0]        w;
    int                 op;
    logic [2:0]         rd, rs, rt;
    logic [4:0]         ea;
    logic [7:0]         nxt;
    logic signed [31:0] a, b, d, s6, s9;
    if (m_halt) return;
    w   = m_imem[m_pc];
    op  = int'(w[15:12]);
    rd  = w[11:9];
    rs  = w[8:6];
    rt  = w[2:0];
    s6  = 32'($signed(w[5:0]));
    s9  = 32'($signed(w[8:0]));
    a   = m_reg[rs];
    b   = m_reg[rt];
    d   = m_reg[rd];
    ea  = 5'(a + s6);
    nxt = m_pc + 8'd1;
    case (op)
      1:  m_reg[rd] = s9;
      2:  m_reg[rd] = m_mem[ea];
      3:  m_mem[ea] = d;
      4:  m_reg[rd] = a + b;
      5:  m_reg[rd] = a - b;
      6:  m_reg[rd] = a * b;
      7:  m_reg[rd] = a + s6;
      8:  m_reg[rd] = (a > b) ? a : b;
      9:  m_reg[rd] = (a < 0) ? 32'sd0 : a;
      10: if (d != 0) nxt = 8'(int'(m_pc) + int'(s9));
      11: nxt = w[7:0];
      12: if (MAC_EN) m_reg[rd] = d + a * b;
      15: begin m_halt = 1'b1; nxt = m_pc; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic prog_fill_halt();
    for (int i = 0; i < 256; i++) m_imem[8'(i)] = HALT_W;
  endtask

  task automatic mem_randomize();
    for (int i = 0; i < 32; i++) m_mem[5'(i)] = 32'($urandom);
  endtask

  // Hold reset across a clock edge, preload, release on a falling edge.
  task automatic apply_reset(input bit load_mem);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.instructions[8'(i)] = m_imem[8'(i)];
    if (load_mem)
      for (int i = 0; i < 32; i++) dut.memory[5'(i)] = m_mem[5'(i)];
    for (int i = 0; i < 8; i++) m_reg[3'(i)] = '0;
    m_pc   = '0;
    m_halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Lockstep run: model and core advance together, pc/halted compared every cycle.
  task automatic run(input string tag, input int n, input bit stop_on_halt);
    for (int c = 0; c < n; c++) begin
      if (stop_on_halt && m_halt) break;
      @(posedge clk);
      #1;
      model_step();
      check({tag, "/pc"}, 32'(st.pc), 32'(m_pc));
      check({tag, "/halted"}, 32'(st.halted), 32'(m_halt));
    end
    if (stop_on_halt) check({tag, "/halt_in_budget"}, 32'(st.halted), 32'(1'b1));
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s/R%0d", tag, i), dut.regs_q[3'(i)], m_reg[3'(i)]);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s/mem%0d", tag, i), dut.memory[5'(i)], m_mem[5'(i)]);
  endtask

  function automatic logic [15:0] rand_insn();
    int ops [13];
    int op;
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 13, 14};
    op  = ops[$urandom_range(0, 12)];
    if (op == OP_LDI) return i_9(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 511)));
    return i_r(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 63)));
  endfunction

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b0;

    // Reset state from time zero
    repeat (2) @(posedge clk);
    #1;
    check("rst0/pc", 32'(st.pc), 32'd0);
    check("rst0/halted", 32'(st.halted), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("rst0/R%0d", i), dut.regs_q[3'(i)], 32'd0);

    // Basic LDI/ADD/ST/HALT
    prog_fill_halt();
    mem_randomize();
    m_imem[0] = i_9(OP_LDI, 1, 5);
    m_imem[1] = i_9(OP_LDI, 2, -3);
    m_imem[2] = i_r(OP_ADD, 3, 1, 2);
    m_imem[3] = i_r(OP_ST, 3, 0, 0);
    m_imem[4] = HALT_W;
    apply_reset(1'b1);
    run("basic", 20, 1'b1);
    compare_state("basic");
    check("basic/mem0", dut.memory[0], 32'd2);
    check("basic/pc_final", 32'(st.pc), 32'd4);
    run("basic_hold", 4, 1'b0);
    check("basic_hold/mem0", dut.memory[0], 32'd2);

    // ReLU loop over four words, plus wrap-around addressing (32+1 -> word 1)
    prog_fill_halt();
    mem_randomize();
    m_mem[0] = 32'sd4; m_mem[1] = -32'sd7; m_mem[2] = 32'sd2; m_mem[3] = -32'sd1;
    m_imem[0]  = i_9(OP_LDI, 7, 32);
    m_imem[1]  = i_r(OP_LD, 1, 7, 1);
    m_imem[2]  = i_9(OP_LDI, 4, 4);
    m_imem[3]  = i_9(OP_LDI, 5, 0);
    m_imem[4]  = i_r(OP_LD, 6, 5, 0);
    m_imem[5]  = i_r(OP_RELU, 6, 6, 0);
    m_imem[6]  = i_r(OP_ST, 6, 5, 0);
    m_imem[7]  = i_r(OP_ADDI, 5, 5, 1);
    m_imem[8]  = i_r(OP_ADDI, 4, 4, -1);
    m_imem[9]  = i_9(OP_BNEZ, 4, -5);
    m_imem[10] = HALT_W;
    apply_reset(1'b1);
    run("relu", 100, 1'b1);
    compare_state("relu");
    check("relu/R1_wrapaddr", dut.regs_q[1], 32'hFFFF_FFF9);
    check("relu/mem0", dut.memory[0], 32'd4);
    check("relu/mem1", dut.memory[1], 32'd0);
    check("relu/mem2", dut.memory[2], 32'd2);
    check("relu/mem3", dut.memory[3], 32'd0);

    // Same loop, interrupted by an asynchronous reset partway through
    m_mem[0] = 32'sd4; m_mem[1] = -32'sd7; m_mem[2] = 32'sd2; m_mem[3] = -32'sd1;
    apply_reset(1'b1);
    run("midrst", 16, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("midrst/pc_async", 32'(st.pc), 32'd0);
    check("midrst/halted_async", 32'(st.halted), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("midrst/R%0d_async", i), dut.regs_q[3'(i)], 32'd0);
    check("midrst/mem1_kept", dut.memory[1], 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("midrst/mem%0d_kept", i), dut.memory[5'(i)], m_mem[5'(i)]);
    apply_reset(1'b0);
    run("rerun", 100, 1'b1);
    compare_state("rerun");
    check("rerun/mem1", dut.memory[1], 32'd0);
    check("rerun/mem3", dut.memory[3], 32'd0);

    // Arithmetic corners: MUL sign, ADD overflow wrap, signed MAX, rd==rs, SUB
    prog_fill_halt();
    mem_randomize();
    m_mem[5] = 32'sh7FFF_FFFF;
    m_imem[0]  = i_9(OP_LDI, 2, -6);
    m_imem[1]  = i_9(OP_LDI, 3, 7);
    m_imem[2]  = i_r(OP_MUL, 1, 2, 3);
    m_imem[3]  = i_r(OP_LD, 4, 0, 5);
    m_imem[4]  = i_9(OP_LDI, 5, 1);
    m_imem[5]  = i_r(OP_ADD, 6, 4, 5);
    m_imem[6]  = i_9(OP_LDI, 2, -2);
    m_imem[7]  = i_9(OP_LDI, 3, -9);
    m_imem[8]  = i_r(OP_MAX, 7, 2, 3);
    m_imem[9]  = i_r(OP_ADD, 5, 5, 5);
    m_imem[10] = i_r(OP_SUB, 0, 3, 2);
    m_imem[11] = i_r(OP_MAX, 4, 3, 2);
    m_imem[12] = HALT_W;
    apply_reset(1'b1);
    run("arith", 40, 1'b1);
    compare_state("arith");
    check("arith/mul", dut.regs_q[1], 32'hFFFF_FFD6);
    check("arith/add_wrap", dut.regs_q[6], 32'h8000_0000);
    check("arith/max", dut.regs_q[7], 32'hFFFF_FFFE);
    check("arith/max_swapped", dut.regs_q[4], 32'hFFFF_FFFE);
    check("arith/double", dut.regs_q[5], 32'd2);
    check("arith/sub", dut.regs_q[0], 32'hFFFF_FFF9);
    check("arith/pc_final", 32'(st.pc), 32'd12);

    // MAC (configuration dependent) and reserved opcodes D/E
    prog_fill_halt();
    m_imem[0] = i_9(OP_LDI, 1, 10);
    m_imem[1] = i_9(OP_LDI, 2, 3);
    m_imem[2] = i_9(OP_LDI, 3, 4);
    m_imem[3] = i_r(OP_MAC, 1, 2, 3);
    m_imem[4] = i_r(13, 1, 1, 1);
    m_imem[5] = i_r(14, 1, 1, 1);
    m_imem[6] = HALT_W;
    apply_reset(1'b0);
    run("mac", 20, 1'b1);
    compare_state("mac");
    check("mac/R1", dut.regs_q[1], MAC_EN ? 32'd22 : 32'd10);
    check("mac/pc_final", 32'(st.pc), 32'd6);

    // Control flow: forward branch, JMP, negative branch, pc wrap 255 -> 0
    prog_fill_halt();
    m_imem[0]   = i_9(OP_BNEZ, 4, 10);
    m_imem[1]   = i_9(OP_LDI, 1, 1);
    m_imem[2]   = i_9(OP_BNEZ, 1, 2);
    m_imem[4]   = i_9(OP_JMP, 0, 250);
    m_imem[250] = i_9(OP_LDI, 2, -1);
    m_imem[251] = i_9(OP_BNEZ, 2, -254);
    m_imem[253] = i_9(OP_LDI, 3, 77);
    m_imem[254] = i_r(OP_ADDI, 3, 3, 1);
    m_imem[255] = i_r(OP_ADDI, 4, 4, 1);
    apply_reset(1'b0);
    run("flow", 40, 1'b1);
    compare_state("flow");
    check("flow/R3", dut.regs_q[3], 32'd78);
    check("flow/R4", dut.regs_q[4], 32'd1);
    check("flow/pc_final", 32'(st.pc), 32'd10);

    // BNEZ with zero offset spins on itself
    prog_fill_halt();
    m_imem[0] = i_9(OP_LDI, 1, 1);
    m_imem[1] = i_9(OP_BNEZ, 1, 0);
    apply_reset(1'b0);
    run("spin", 8, 1'b0);
    check("spin/pc", 32'(st.pc), 32'd1);
    check("spin/halted", 32'(st.halted), 32'd0);

    // Random straight-line programs
    for (int t = 0; t < 6; t++) begin
      prog_fill_halt();
      mem_randomize();
      for (int i = 0; i < 48; i++) m_imem[8'(i)] = rand_insn();
      apply_reset(1'b1);
      run($sformatf("rnd%0d", t), 100, 1'b1);
      compare_state($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
